// File: rtl/demux_1xn_stream_if.sv
// demux_1xn_stream_if: input stream, four output slots and lock status of the 1:4 packet demux
interface demux_1xn_stream_if #(
    parameter int BUS_WIDTH = 5
);
    logic [BUS_WIDTH-1:0] D;
    logic [1:0]           sel;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] Y0;
    logic [BUS_WIDTH-1:0] Y1;
    logic [BUS_WIDTH-1:0] Y2;
    logic [BUS_WIDTH-1:0] Y3;
    logic [3:0]           out_valid;
    logic [3:0]           out_last;
    logic [3:0]           out_ready;
    logic                 busy;
    logic [1:0]           cur_sel;

    modport master (
        output D, sel, in_valid, in_last, out_ready,
        input  in_ready, Y0, Y1, Y2, Y3, out_valid, out_last, busy, cur_sel
    );

    modport slave (
        input  D, sel, in_valid, in_last, out_ready,
        output in_ready, Y0, Y1, Y2, Y3, out_valid, out_last, busy, cur_sel
    );
endinterface

// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: steers whole packets from one input stream into one of four registered output slots
module demux_1xn_stream #(
    parameter int BUS_WIDTH = 5
) (
    input logic               clk,
    input logic               rst_n,
    demux_1xn_stream_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t               state, state_nxt;
    logic [1:0]           tgt;
    logic [1:0]           cur_sel;
    logic                 in_ready;
    logic                 accept;
    logic [BUS_WIDTH-1:0] y [4];
    logic [3:0]           out_valid;
    logic [3:0]           out_last;

    // target channel comes from sel only on a packet's first beat; only that slot gates in_ready
    always_comb begin
        tgt       = (state == LOCKED) ? cur_sel : bus.sel;
        in_ready  = ~out_valid[tgt] | bus.out_ready[tgt];
        accept    = bus.in_valid & in_ready;
        state_nxt = accept ? (bus.in_last ? IDLE : LOCKED) : state;
    end

    // packet lock: remember the channel when a multi-beat packet starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_sel <= '0;
        end else begin
            state <= state_nxt;
            if (accept && state == IDLE && !bus.in_last) cur_sel <= bus.sel;
        end
    end

    // one-entry slot per channel: load wins over drain, drain leaves data and last untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_last  <= '0;
            for (int k = 0; k < 4; k++) y[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && tgt == 2'(k)) begin
                    y[k]         <= bus.D;
                    out_last[k]  <= bus.in_last;
                    out_valid[k] <= 1'b1;
                end else if (bus.out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.Y0        = y[0];
    assign bus.Y1        = y[1];
    assign bus.Y2        = y[2];
    assign bus.Y3        = y[3];
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.busy      = (state == LOCKED);
    assign bus.cur_sel   = cur_sel;
endmodule

// File: tb/tb_demux_1xn_stream.sv
// tb_demux_1xn_stream: directed packets checked against a per-channel queue model every cycle
module tb_demux_1xn_stream;
    localparam int BW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    demux_1xn_stream_if #(.BUS_WIDTH(BW)) bus ();

    demux_1xn_stream #(.BUS_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // model: each channel is a FIFO of {last,data} words of depth one, plus the packet lock
    logic [BW:0] q [4][$];
    bit          mlock;
    int          mch;
    int          mt;
    bit          macc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] yk(input int k);
        return k == 0 ? bus.Y0 : k == 1 ? bus.Y1 : k == 2 ? bus.Y2 : bus.Y3;
    endfunction

    function automatic bit exp_ready();
        int t;
        t = mlock ? mch : int'(bus.sel);
        return q[t].size() == 0 || bus.out_ready[t];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) q[k].delete();
            mlock = 1'b0;
            mch   = 0;
        end else begin
            mt   = mlock ? mch : int'(bus.sel);
            macc = bus.in_valid && exp_ready();
            for (int k = 0; k < 4; k++)
                if (q[k].size() != 0 && bus.out_ready[k]) void'(q[k].pop_front());
            if (macc) begin
                q[mt].push_back({bus.in_last, bus.D});
                if (!mlock && !bus.in_last) begin
                    mlock = 1'b1;
                    mch   = int'(bus.sel);
                end else if (bus.in_last) begin
                    mlock = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] ev;
            logic [3:0] el;
            ev = '0;
            el = '0;
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0) begin
                    ev[k] = 1'b1;
                    el[k] = q[k][0][BW];
                    chk($sformatf("Y%0d", k), 32'(yk(k)), 32'(q[k][0][BW-1:0]));
                end
            end
            chk("out_valid", 32'(bus.out_valid), 32'(ev));
            chk("out_last", 32'(bus.out_last & ev), 32'(el));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
            chk("busy", 32'(bus.busy), 32'(mlock));
            chk("cur_sel", 32'(bus.cur_sel), 32'(mch));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [BW-1:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.sel      = s;
        bus.D        = d;
        bus.in_last  = l;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.sel       = '0;
        bus.D         = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = '0;
        repeat (2) cyc();
        chk("reset out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // reset in the middle of a packet to ch2
        bus.out_ready = 4'hF;
        drive(2'd2, 5'h07, 1'b0);
        cyc();
        drive(2'd2, 5'h08, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        chk("pre-reset busy", 32'(bus.busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(bus.out_valid), 32'h0);
        chk("async busy", 32'(bus.busy), 32'h0);
        chk("async Y2", 32'(bus.Y2), 32'h0);
        #1 rst_n = 1'b1;
        drive(2'd1, 5'h0A, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("post-reset Y1", 32'(bus.Y1), 32'h0A);
        chk("post-reset out_valid", 32'(bus.out_valid), 32'h2);

        // single-beat routing to every channel
        for (int i = 0; i < 4; i++) begin
            drive(2'(i), 5'(5'h11 + i), 1'b1);
            cyc();
            chk($sformatf("single Y%0d", i), 32'(yk(i)), 32'(5'h11 + i));
            chk($sformatf("single out_valid %0d", i), 32'(bus.out_valid), 32'(1 << i));
            chk("single busy", 32'(bus.busy), 32'h0);
        end
        bus.in_valid = 1'b0;
        cyc();
        chk("single drained", 32'(bus.out_valid), 32'h0);

        // four-beat packet locked to ch3 while sel wanders
        drive(2'd3, 5'd1, 1'b0);
        cyc();
        chk("lock busy", 32'(bus.busy), 32'h1);
        chk("lock cur_sel", 32'(bus.cur_sel), 32'h3);
        chk("lock Y3 b1", 32'(bus.Y3), 32'h1);
        drive(2'd0, 5'd2, 1'b0);
        cyc();
        chk("lock Y3 b2", 32'(bus.Y3), 32'h2);
        drive(2'd0, 5'd3, 1'b0);
        cyc();
        drive(2'd0, 5'd4, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("lock Y3 b4", 32'(bus.Y3), 32'h4);
        chk("lock last", 32'(bus.out_last[3]), 32'h1);
        chk("lock out_valid", 32'(bus.out_valid), 32'h8);
        chk("lock done busy", 32'(bus.busy), 32'h0);
        cyc();

        // backpressure on ch1
        bus.out_ready = 4'b1101;
        drive(2'd1, 5'h05, 1'b0);
        cyc();
        drive(2'd1, 5'h06, 1'b0);
        #1;
        chk("bp in_ready", 32'(bus.in_ready), 32'h0);
        cyc();
        cyc();
        chk("bp Y1 held", 32'(bus.Y1), 32'h05);
        bus.out_ready = 4'hF;
        #1;
        chk("bp in_ready open", 32'(bus.in_ready), 32'h1);
        cyc();
        chk("bp Y1 w2", 32'(bus.Y1), 32'h06);
        drive(2'd1, 5'h07, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("bp Y1 w3", 32'(bus.Y1), 32'h07);
        chk("bp last", 32'(bus.out_last[1]), 32'h1);
        cyc();

        // ch0 stalled while a packet flows to ch2
        bus.out_ready = 4'b1110;
        drive(2'd0, 5'h1F, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        chk("iso Y0", 32'(bus.Y0), 32'h1F);
        drive(2'd2, 5'h09, 1'b0);
        cyc();
        chk("iso Y2 b1", 32'(bus.Y2), 32'h09);
        drive(2'd2, 5'h0A, 1'b0);
        cyc();
        chk("iso Y2 b2", 32'(bus.Y2), 32'h0A);
        drive(2'd2, 5'h0B, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("iso Y2 b3", 32'(bus.Y2), 32'h0B);
        chk("iso Y0 held", 32'(bus.Y0), 32'h1F);
        chk("iso ch0 valid", 32'(bus.out_valid[0]), 32'h1);
        bus.out_ready = 4'hF;
        cyc();

        // load and drain of ch1 in the same cycle
        bus.out_ready = 4'b1101;
        drive(2'd1, 5'h03, 1'b1);
        cyc();
        bus.out_ready = 4'hF;
        drive(2'd1, 5'h04, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("sim out_valid1", 32'(bus.out_valid[1]), 32'h1);
        chk("sim Y1", 32'(bus.Y1), 32'h04);
        cyc();
        chk("sim drained", 32'(bus.out_valid), 32'h0);

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
